mem_req_arbiter: RTL

Parametrised memory request arbiter for the single-cycle RISC-V core. It multiplexes NPORTS requesters (instruction fetch, data load/store, FPGA loader, …) onto one single-port synchronous word RAM. It converts byte addresses to word addresses and tolerates multi-cycle RAM read latency. It returns per-port responses with error flags, and offers fixed-priority or round-robin arbitration.

---
 rtl/mem_req_arbiter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Purpose:
//   Shares one single-port synchronous word RAM among NPORTS requesters, for
//   example instruction fetch, data load/store and an FPGA loader. Requesters
//   present byte addresses, which are converted to word addresses. Misaligned
//   and out-of-range requests are answered with an error response and never
//   reach the RAM. The arbiter tolerates RAM_LAT cycles of read latency. The
//   grant policy is fixed priority (port 0 highest) or round robin.
//
//   Transaction flow, with the accept in cycle T:
//     IDLE   (T)       grant one valid port; req_ready strobes for that port
//     ACCESS (T+1)     ram_addr/ram_din driven; ram_we high for writes only
//     WAIT             reads only; RAM_LAT cycles, the last one samples ram_dout
//     RESP             one-cycle rsp_valid pulse for the granted port
//   An erroneous request goes straight from IDLE to RESP, so its response
//   appears in T+1.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   req_valid  [NPORTS]          per-port request valid
//   req_write  [NPORTS]          per-port 1 = write, 0 = read
//   req_addr   [NPORTS*ADDR_W]   per-port byte address, port i at [i*ADDR_W +: ADDR_W]
//   req_wdata  [NPORTS*DATA_W]   per-port write data
//   req_ready  [NPORTS]          one-hot accept strobe (combinational)
//   rsp_valid  [NPORTS]          one-hot response pulse (registered)
//   rsp_err                      error flag, qualified by any rsp_valid
//   rsp_rdata  [DATA_W]          read data, held between responses
//   ram_addr   [RAM_AW]          RAM word address (registered, held outside ACCESS)
//   ram_we                       RAM write enable (registered, ACCESS cycle only)
//   ram_din    [DATA_W]          RAM write data (registered, held outside ACCESS)
//   ram_dout   [DATA_W]          RAM read data
//   busy                         high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
   parameter int NPORTS  = 2,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int RAM_AW  = 12,
   parameter int RAM_LAT = 1,
   parameter int RR_MODE = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORTS-1:0]        req_valid,
   input  logic [NPORTS-1:0]        req_write,
   input  logic [NPORTS*ADDR_W-1:0] req_addr,
   input  logic [NPORTS*DATA_W-1:0] req_wdata,
   output logic [NPORTS-1:0]        req_ready,
   output logic [NPORTS-1:0]        rsp_valid,
   output logic                     rsp_err,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic [RAM_AW-1:0]        ram_addr,
   output logic                     ram_we,
   output logic [DATA_W-1:0]        ram_din,
   input  logic [DATA_W-1:0]        ram_dout,
   output logic                     busy
);

   // Port-index width and WAIT counter width. The counter holds up to RAM_LAT-1.
   localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state;
   state_t            next_state;

   // Round-robin pointer: the most recently accepted port.
   logic [PW-1:0]     rr_ptr;

   // Transaction context captured at accept.
   logic [PW-1:0]     cur_port;
   logic              cur_write;
   logic [CW-1:0]     wait_cnt;

   // Arbitration results for the current cycle.
   logic              gnt_found;
   logic [PW-1:0]     gnt_idx;
   logic [PW:0]       cand;
   logic              accept;

   // Request fields of the granted port.
   logic [ADDR_W-1:0] addr_arr  [NPORTS];
   logic [DATA_W-1:0] wdata_arr [NPORTS];
   logic [ADDR_W-1:0] sel_addr;
   logic [ADDR_W-1:0] sel_waddr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_write;
   logic              sel_misaligned;
   logic              sel_out_of_range;
   logic              sel_err;

   function automatic logic [NPORTS-1:0] to_onehot(input logic [PW-1:0] idx);
      logic [NPORTS-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

   // Split the flat request buses into per-port words.
   for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
   end

   // ---------------------------------------------------------------------------
   // Arbitration. Candidates are visited in priority order and the first valid
   // one wins. In round-robin mode the scan starts one past the last winner
   // and wraps modulo NPORTS. In fixed mode it starts at port 0.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable assigned in this block gets a default first, so
      // no path leaves one unassigned and no latch is inferred.
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NPORTS; k++) begin
         if (RR_MODE != 0) begin
            cand = (PW+1)'(rr_ptr) + (PW+1)'(k);
            if (cand >= (PW+1)'(NPORTS)) begin
               cand = cand - (PW+1)'(NPORTS);
            end
         end else begin
            cand = (PW+1)'(k - 1);
         end
         if (!gnt_found && req_valid[cand[PW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[PW-1:0];
         end
      end
   end

   // Grants are offered only in IDLE and never while reset is asserted.
   assign accept    = !rst && (state == IDLE) && gnt_found;
   assign req_ready = accept ? to_onehot(gnt_idx) : '0;

   // Decode the granted request.
   assign sel_addr         = addr_arr[gnt_idx];
   assign sel_wdata        = wdata_arr[gnt_idx];
   assign sel_write        = req_write[gnt_idx];
   assign sel_waddr        = sel_addr >> 2;
   assign sel_misaligned   = (sel_addr[1:0] != 2'b00);
   // Any word-address bit at or above RAM_AW means the access misses the RAM.
   assign sel_out_of_range = ((sel_waddr >> RAM_AW) != '0);
   assign sel_err          = sel_misaligned || sel_out_of_range;

   // ---------------------------------------------------------------------------
   // Next-state logic.
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = sel_err ? RESP : ACCESS;
            end
         end
         ACCESS:  next_state = cur_write ? RESP : WAIT;
         WAIT: begin
            if (wait_cnt == '0) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register and registered datapath.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: rst is sampled here at the clock edge, so it acts synchronously.
      // There are no storage arrays, so every register, including the datapath
      // registers, is cleared. Any in-flight access is dropped without a
      // response.
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= PW'(NPORTS - 1);
         cur_port  <= '0;
         cur_write <= 1'b0;
         wait_cnt  <= '0;
         rsp_valid <= '0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_din   <= '0;
         busy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout. Every right-hand side
         // sees the pre-edge values, independent of statement order.
         state     <= next_state;
         busy      <= (next_state != IDLE);
         // Single-cycle strobes fall back to zero unless re-asserted below.
         ram_we    <= 1'b0;
         rsp_valid <= '0;
         rsp_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  cur_port  <= gnt_idx;
                  cur_write <= sel_write;
                  rr_ptr    <= gnt_idx;
                  if (sel_err) begin
                     // Rejected request: the RAM is left untouched and the
                     // error response lands in the next cycle.
                     rsp_valid <= to_onehot(gnt_idx);
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     ram_addr <= sel_waddr[RAM_AW-1:0];
                     ram_we   <= sel_write;
                     if (sel_write) begin
                        ram_din <= sel_wdata;
                     end
                  end
               end
            end
            ACCESS: begin
               // WAIT runs for RAM_LAT cycles. Its last cycle sees valid ram_dout.
               wait_cnt <= CW'(RAM_LAT - 1);
               if (cur_write) begin
                  rsp_valid <= to_onehot(cur_port);
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  rsp_rdata <= ram_dout;
                  rsp_valid <= to_onehot(cur_port);
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: begin
               // RESP: the response pulse is already on the outputs.
            end
         endcase
      end
   end

endmodule
